// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressable little-endian RV32 data RAM with request/response handshake
// Optional feature macro: DMEM_MISALIGN_EN (split word-crossing accesses over two word-cycles)
`timescale 1ns/1ps

module dmem_ctrl #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int BA    = $clog2(DEPTH_BYTES);
  localparam int WA    = BA - 2;

`ifdef DMEM_MISALIGN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, SPLIT = 2'd2, RESP = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd3} state_e;
`endif

  state_e state_q, state_d;

  // Word-organised storage; each byte lane has its own write enable.
  logic [31:0] mem_q [WORDS];

  // Request fields captured at acceptance.
  logic [BA-1:0] addr_q;
  logic          we_q;
  logic [2:0]    funct3_q;
  logic [31:0]   wdata_q;
  logic [3:0]    mask_q;
  logic          err_q;
  logic [31:0]   raw_q;   // load bytes gathered so far, byte 0 = byte at addr
`ifdef DMEM_MISALIGN_EN
  logic          cross_q;
`endif

  // Acceptance-time decode.
  logic            accept;
  logic            f3_legal;
  logic [2:0]      size_m1;
  logic [3:0]      size_mask;
  logic [ADDR_W:0] last_byte;
  logic            range_err;
  logic            acc_err;
`ifdef DMEM_MISALIGN_EN
  logic            acc_cross;
`else
  logic            misal;
`endif

  // Access-time byte-lane steering.
  logic [1:0]    off;
  logic [WA-1:0] w0;
  logic [31:0]   lo_data;
  logic [3:0]    lo_be;
`ifdef DMEM_MISALIGN_EN
  logic [WA-1:0] w1;
  logic [31:0]   hi_data;
  logic [3:0]    hi_be;
  logic [1:0]    hi_sh;
`endif

  // Memory write port.
  logic [3:0]    wr_be;
  logic [WA-1:0] wr_idx;
  logic [31:0]   wr_data;

  assign accept = req_valid && req_ready;

  // Decode size/legality of the incoming request and flag range/alignment errors.
  always_comb begin
    f3_legal  = 1'b1;
    size_m1   = 3'd0;
    size_mask = 4'b0001;
    case (req_funct3)
      3'b000: begin size_m1 = 3'd0; size_mask = 4'b0001; end
      3'b001: begin size_m1 = 3'd1; size_mask = 4'b0011; end
      3'b010: begin size_m1 = 3'd3; size_mask = 4'b1111; end
      3'b100: begin size_m1 = 3'd0; size_mask = 4'b0001; f3_legal = !req_we; end
      3'b101: begin size_m1 = 3'd1; size_mask = 4'b0011; f3_legal = !req_we; end
      default: f3_legal = 1'b0;
    endcase
    // One extra bit so an address near the top of the address space cannot wrap.
    last_byte = {1'b0, req_addr} + (ADDR_W+1)'(size_m1);
    range_err = last_byte >= (ADDR_W+1)'(DEPTH_BYTES);
`ifdef DMEM_MISALIGN_EN
    acc_cross = ({1'b0, req_addr[1:0]} + size_m1) > 3'd3;
    acc_err   = !f3_legal || range_err;
`else
    misal     = ((size_m1 == 3'd1) && req_addr[0]) ||
                ((size_m1 == 3'd3) && (req_addr[1:0] != 2'b00));
    acc_err   = !f3_legal || range_err || misal;
`endif
  end

  assign off = addr_q[1:0];
  assign w0  = addr_q[BA-1:2];

`ifdef DMEM_MISALIGN_EN
  // Shift data and enables across a 64-bit window: low half hits w0, high half hits w0+1.
  assign w1                 = w0 + 1'b1;
  assign {hi_data, lo_data} = {32'b0, wdata_q} << {off, 3'b000};
  assign {hi_be, lo_be}     = {4'b0, mask_q} << off;
  assign hi_sh              = 2'd0 - off;
`else
  assign lo_data = wdata_q << {off, 3'b000};
  assign lo_be   = mask_q << off;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: errors skip straight to RESP, crossing accesses take the SPLIT detour.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: begin
        if (req_valid) begin
          state_d = acc_err ? RESP : ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
`ifdef DMEM_MISALIGN_EN
        state_d = cross_q ? SPLIT : RESP;
`else
        state_d = RESP;
`endif
      end
`ifdef DMEM_MISALIGN_EN
      SPLIT: state_d = RESP;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshake flags from state, response data extended from the captured bytes.
  always_comb begin
    req_ready  = (state_q == IDLE) || (state_q == RESP);
    resp_valid = (state_q == RESP);
    resp_err   = resp_valid && err_q;
    resp_rdata = 32'h0;
    if (resp_valid && !err_q && !we_q) begin
      case (funct3_q)
        3'b000:  resp_rdata = {{24{raw_q[7]}}, raw_q[7:0]};
        3'b001:  resp_rdata = {{16{raw_q[15]}}, raw_q[15:0]};
        3'b010:  resp_rdata = raw_q;
        3'b100:  resp_rdata = {24'h0, raw_q[7:0]};
        3'b101:  resp_rdata = {16'h0, raw_q[15:0]};
        default: resp_rdata = 32'h0;
      endcase
    end
  end

  // Capture request fields at acceptance and gather load bytes during the access cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0;
      mask_q   <= 4'b0000;
      err_q    <= 1'b0;
      raw_q    <= 32'h0;
`ifdef DMEM_MISALIGN_EN
      cross_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_q   <= req_addr[BA-1:0];
        we_q     <= req_we;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
        mask_q   <= size_mask;
        err_q    <= acc_err;
        raw_q    <= 32'h0;
`ifdef DMEM_MISALIGN_EN
        cross_q  <= acc_cross;
`endif
      end else if (state_q == ACCESS) begin
        raw_q <= mem_q[w0] >> {off, 3'b000};
      end
`ifdef DMEM_MISALIGN_EN
      else if (state_q == SPLIT) begin
        raw_q <= raw_q | (mem_q[w1] << {hi_sh, 3'b000});
      end
`endif
    end
  end

  // Select which word and lanes a store touches in the current access cycle.
  always_comb begin
    wr_be   = 4'b0000;
    wr_idx  = w0;
    wr_data = lo_data;
    if ((state_q == ACCESS) && we_q) begin
      wr_be = lo_be;
    end
`ifdef DMEM_MISALIGN_EN
    if ((state_q == SPLIT) && we_q) begin
      wr_be   = hi_be;
      wr_idx  = w1;
      wr_data = hi_data;
    end
`endif
  end

  // Byte-enabled RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) begin
        mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl with a byte-array reference model
`timescale 1ns/1ps

module tb_dmem_ctrl;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] model [DEPTH];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
  } vec_t;

  dmem_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: size/legality table, byte-granular memory, latency = edges from accept to resp.
  function automatic void ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wd, output logic [31:0] rd,
                                     output logic er, output int lat);
    int size;
    bit legal;
    longint a;
    a = {32'b0, addr};
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    legal = (size != 0) && !(we && f3 >= 3'd4);
    rd = 32'h0; er = 1'b0; lat = 0;
    if (!legal || (a + size - 1 >= DEPTH)) er = 1'b1;
`ifndef DMEM_MISALIGN_EN
    else if (a % size != 0) er = 1'b1;
`endif
    if (!er) begin
      lat = ((a / 4) == ((a + size - 1) / 4)) ? 1 : 2;
      if (we) begin
        for (int i = 0; i < size; i++) model[int'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) rd[8*i +: 8] = model[int'(a) + i];
        if (f3 == 3'd0) rd = {{24{rd[7]}}, rd[7:0]};
        if (f3 == 3'd1) rd = {{16{rd[15]}}, rd[15:0]};
      end
    end
  endfunction

  // Drives one request (called #1 after a rising edge) and returns the response; lat = -1 on timeout.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_at_request got %b exp 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = -1; rd = 'x; er = 'x;
    for (int k = 0; k < 8; k++) begin
      if (resp_valid === 1'b1) begin
        lat = k; rd = resp_rdata; er = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b valid=%b rdata=%h err=%b exp 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    logic [31:0] rd, mrd, wd;
    logic er, mer;
    int lat, mlat;
    for (int w = 0; w < DEPTH / 4; w++) begin
      wd = $urandom;
      ref_access(1'b1, 3'd2, 32'(w * 4), wd, mrd, mer, mlat);
      xact(1'b1, 3'd2, 32'(w * 4), wd, rd, er, lat);
      checks++;
      if (er !== 1'b0 || lat != 1 || rd !== 32'h0) begin
        errors++;
        $display("FAIL fill[%0d] got err=%b lat=%0d rd=%h exp 0 1 0", w, er, lat, rd);
      end
    end
  endtask

  task automatic test_directed();
    vec_t t[10];
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, mlat;
    t = '{'{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1},
          '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1},
          '{1'b0, 3'd0, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 1},
          '{1'b0, 3'd4, 32'h10, 32'h0,        32'h000000EF, 1'b0, 1},
          '{1'b0, 3'd1, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 1},
          '{1'b0, 3'd5, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, 1},
          '{1'b1, 3'd0, 32'h11, 32'hFFFFFF55, 32'h0,        1'b0, 1},
          '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 1},
          '{1'b1, 3'd1, 32'h12, 32'hABCD1234, 32'h0,        1'b0, 1},
          '{1'b0, 3'd2, 32'h10, 32'h0,        32'h123455EF, 1'b0, 1}};
    for (int i = 0; i < 10; i++) begin
      ref_access(t[i].we, t[i].f3, t[i].addr, t[i].wd, mrd, mer, mlat);
      xact(t[i].we, t[i].f3, t[i].addr, t[i].wd, rd, er, lat);
      checks++;
      if (rd !== t[i].rd || er !== t[i].er || lat != t[i].lat) begin
        errors++;
        $display("FAIL directed[%0d] got rd=%h err=%b lat=%0d exp rd=%h err=%b lat=%0d",
                 i, rd, er, lat, t[i].rd, t[i].er, t[i].lat);
      end
    end
  endtask

  task automatic test_errors();
    vec_t t[8];
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, mlat;
    t = '{'{1'b0, 3'd2, 32'(DEPTH - 2), 32'h0,        32'h0, 1'b1, 0},
          '{1'b0, 3'd3, 32'h10,         32'h0,        32'h0, 1'b1, 0},
          '{1'b1, 3'd4, 32'h10,         32'hCAFEF00D, 32'h0, 1'b1, 0},
          '{1'b1, 3'd1, 32'(DEPTH - 1), 32'hCAFEF00D, 32'h0, 1'b1, 0},
          '{1'b0, 3'd0, 32'hFFFFFFFF,   32'h0,        32'h0, 1'b1, 0},
          '{1'b1, 3'd7, 32'h10,         32'hCAFEF00D, 32'h0, 1'b1, 0},
          '{1'b0, 3'd2, 32'(DEPTH - 4), 32'h0,        32'h0, 1'b0, 1},
          '{1'b0, 3'd4, 32'(DEPTH - 1), 32'h0,        32'h0, 1'b0, 1}};
    for (int i = 0; i < 8; i++) begin
      ref_access(t[i].we, t[i].f3, t[i].addr, t[i].wd, mrd, mer, mlat);
      if (!t[i].er) t[i].rd = mrd;
      xact(t[i].we, t[i].f3, t[i].addr, t[i].wd, rd, er, lat);
      checks++;
      if (rd !== t[i].rd || er !== t[i].er || lat != t[i].lat) begin
        errors++;
        $display("FAIL errors[%0d] got rd=%h err=%b lat=%0d exp rd=%h err=%b lat=%0d",
                 i, rd, er, lat, t[i].rd, t[i].er, t[i].lat);
      end
    end
    xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h123455EF || er !== 1'b0) begin
      errors++;
      $display("FAIL errors_mem_unchanged got rd=%h err=%b exp 123455ef 0", rd, er);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, mlat;
    ref_access(1'b1, 3'd2, 32'h13, 32'hA1B2C3D4, mrd, mer, mlat);
    xact(1'b1, 3'd2, 32'h13, 32'hA1B2C3D4, rd, er, lat);
`ifdef DMEM_MISALIGN_EN
    checks++;
    if (er !== 1'b0 || lat != 2 || rd !== 32'h0) begin
      errors++;
      $display("FAIL split_store got err=%b lat=%0d rd=%h exp 0 2 0", er, lat, rd);
    end
    xact(1'b0, 3'd2, 32'h13, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hA1B2C3D4 || er !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL split_load got rd=%h err=%b lat=%0d exp a1b2c3d4 0 2", rd, er, lat);
    end
    xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hD43455EF || er !== 1'b0) begin
      errors++;
      $display("FAIL split_low_word got rd=%h err=%b exp d43455ef 0", rd, er);
    end
`else
    checks++;
    if (er !== 1'b1 || lat != 0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_store got err=%b lat=%0d rd=%h exp 1 0 0", er, lat, rd);
    end
    xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h123455EF || er !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_no_write got rd=%h err=%b exp 123455ef 0", rd, er);
    end
`endif
  endtask

  task automatic test_pulse();
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, mlat;
    @(posedge clk); #1;
    ref_access(1'b0, 3'd2, 32'h20, 32'h0, mrd, mer, mlat);
    xact(1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
    checks++;
    if (rd !== mrd || er !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL pulse_resp got rd=%h err=%b lat=%0d exp %h 0 1", rd, er, lat, mrd);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL pulse_rest got valid=%b rdata=%h err=%b ready=%b exp 0 0 0 1",
               resp_valid, resp_rdata, resp_err, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, mlat, c0, a;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, DEPTH / 4 - 1) * 4;
      ref_access(1'b0, 3'd2, 32'(a), 32'h0, mrd, mer, mlat);
      xact(1'b0, 3'd2, 32'(a), 32'h0, rd, er, lat);
      checks++;
      if (rd !== mrd || er !== 1'b0 || lat != 1) begin
        errors++;
        $display("FAIL b2b[%0d] got rd=%h err=%b lat=%0d exp %h 0 1", i, rd, er, lat, mrd);
      end
    end
    checks++;
    if (cyc - c0 != 16) begin
      errors++;
      $display("FAIL b2b_throughput got %0d cycles exp 16", cyc - c0);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, mlat, seen;
    // Abort in ACCESS: the store never commits.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1; #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_access_outputs got valid=%b ready=%b exp 0 1", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ref_access(1'b0, 3'd2, 32'h40, 32'h0, mrd, mer, mlat);
    xact(1'b0, 3'd2, 32'h40, 32'h0, rd, er, lat);
    checks++;
    if (rd !== mrd || er !== 1'b0) begin
      errors++;
      $display("FAIL abort_access_nowrite got rd=%h err=%b exp %h 0", rd, er, mrd);
    end
`ifdef DMEM_MISALIGN_EN
    // Abort in SPLIT: low half already written, high half untouched.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h1E; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_split_outputs got valid=%b ready=%b exp 0 1", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_split_noresp got %0d resp cycles exp 0", seen);
    end
    model[32'h1E] = 8'h44;
    model[32'h1F] = 8'h33;
    xact(1'b0, 3'd5, 32'h1E, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00003344 || er !== 1'b0) begin
      errors++;
      $display("FAIL abort_split_low got rd=%h err=%b exp 00003344 0", rd, er);
    end
    ref_access(1'b0, 3'd5, 32'h20, 32'h0, mrd, mer, mlat);
    xact(1'b0, 3'd5, 32'h20, 32'h0, rd, er, lat);
    checks++;
    if (rd !== mrd || er !== 1'b0) begin
      errors++;
      $display("FAIL abort_split_high got rd=%h err=%b exp %h 0", rd, er, mrd);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] rd, mrd, addr, wd;
    logic [2:0] f3;
    logic er, mer, we;
    int lat, mlat, r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      addr = 32'($urandom_range(0, DEPTH - 1));
      else if (r < 9) addr = 32'(DEPTH - 6 + $urandom_range(0, 9));
      else            addr = $urandom;
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      ref_access(we, f3, addr, wd, mrd, mer, mlat);
      xact(we, f3, addr, wd, rd, er, lat);
      checks++;
      if (rd !== mrd || er !== mer || lat != mlat) begin
        errors++;
        $display("FAIL rand[%0d] we=%b f3=%0d addr=%h got rd=%h err=%b lat=%0d exp rd=%h err=%b lat=%0d",
                 i, we, f3, addr, rd, er, lat, mrd, mer, mlat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_errors();
    test_misalign();
    test_pulse();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
